// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//
// Purpose : Shared definitions for the game round controller slice.
//           Holds the 2-bit round state type with its encodings, the default
//           clock and tick rates, and the default score width.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package game_pkg;

    // Round state. These encodings leave the block on the state output and are
    // decoded by the display path, so they must not change.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_OVER  = 2'd3;

    localparam int DEFAULT_CLK_HZ     = 100_000_000;
    localparam int DEFAULT_TICK_HZ    = 1;
    localparam int DEFAULT_SCORE_BITS = 8;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//
// Purpose : Free-running modulo-DIV counter that advances only while 'run'
//           is high and holds its value otherwise, so a paused round resumes
//           mid-period. 'tick' is a combinational flag for the last count of
//           a period. The owner registers it before it leaves the chip.
//
// Parameters:
//   DIV    - divide ratio, must be >= 2
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high
//   clear  in   restart the period at count 0 (wins over run)
//   run    in   advance the counter this cycle
//   tick   out  high in the cycle the counter wraps from DIV-1 to 0
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    // Next count: clear restarts the period, run advances it, and otherwise
    // the count holds so a paused round keeps its phase.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !clear && wrap;

endmodule

// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
//
// Purpose : Round-sequencing controller for the countdown game. It holds the
//           countdown timer in reload while idle and generates the slow tick
//           enable while a round runs. It ends the round on timer_done and
//           keeps the live and best scores.
//
// Optional feature macro: GAME_ROUND_CTRL_BEST_SCORE_EN
//   defined   - best-score register and compare are built
//   undefined - best_score is tied to 0 (the port is kept)
//
// Parameters:
//   CLK_HZ      - system clock frequency
//   TICK_HZ     - tick rate; CLK_HZ/TICK_HZ must be >= 2
//   SCORE_BITS  - score counter width
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high
//   start_btn   in   one-cycle pulse: start round / abort / leave OVER
//   pause_btn   in   one-cycle pulse: toggles pause
//   hit         in   one-cycle pulse: scoring event
//   timer_done  in   countdown reached zero
//   load_timer  out  hold the countdown at its start value (high in IDLE)
//   tick_en     out  one-cycle countdown enable pulse
//   state       out  current state (IDLE=0, RUN=1, PAUSE=2, OVER=3)
//   score       out  current round score
//   best_score  out  highest completed-round score
//   round_over  out  one-cycle pulse on entry to OVER
// ---------------------------------------------------------------------------
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int TICK_HZ    = DEFAULT_TICK_HZ,
    parameter int SCORE_BITS = DEFAULT_SCORE_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_btn,
    input  logic                  pause_btn,
    input  logic                  hit,
    input  logic                  timer_done,
    output logic                  load_timer,
    output logic                  tick_en,
    output logic [1:0]            state,
    output logic [SCORE_BITS-1:0] score,
    output logic [SCORE_BITS-1:0] best_score,
    output logic                  round_over
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [SCORE_BITS-1:0] SCORE_MAX = '1;

    state_t                  state_q;
    state_t                  state_d;
    logic [SCORE_BITS-1:0]   score_q;
    logic [SCORE_BITS-1:0]   score_d;
    logic                    tick_en_q;
    logic                    round_over_q;

    logic                    presc_clear;
    logic                    presc_run;
    logic                    presc_tick;
    logic                    ending;

    // The prescaler restarts on the IDLE->RUN edge and only advances in RUN,
    // so PAUSE freezes the tick phase.
    assign presc_clear = (state_q == ST_IDLE) && start_btn;
    assign presc_run   = (state_q == ST_RUN);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .run   (presc_run),
        .tick  (presc_tick)
    );

    // A round ends when timer_done is seen in RUN. It beats pause_btn.
    assign ending = (state_q == ST_RUN) && timer_done;

    // Next-state and next-score logic. A hit in the final RUN cycle is still
    // counted, so score_d carries the final round score into the best-score
    // compare below.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        case (state_q)
            ST_IDLE: begin
                if (start_btn) begin
                    state_d = ST_RUN;
                    score_d = '0;
                end
            end
            ST_RUN: begin
                if (hit && (score_q != SCORE_MAX)) begin
                    score_d = score_q + SCORE_BITS'(1);
                end
                if (timer_done) begin
                    state_d = ST_OVER;
                end else if (pause_btn) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_btn) begin
                    state_d = ST_IDLE;
                end else if (pause_btn) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start_btn) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, score and pulse registers. tick_en is qualified with the next
    // state so that a wrap landing on the cycle we leave RUN does not emit a
    // tick into PAUSE or OVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            tick_en_q    <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            tick_en_q    <= presc_tick && (state_d == ST_RUN);
            round_over_q <= ending;
        end
    end

`ifdef GAME_ROUND_CTRL_BEST_SCORE_EN
    logic [SCORE_BITS-1:0] best_q;
    logic [SCORE_BITS-1:0] best_d;

    // Best score only updates when a round completes normally. An abort from
    // PAUSE never reaches this compare.
    always_comb begin
        best_d = best_q;
        if (ending && (score_d > best_q)) begin
            best_d = score_d;
        end
    end

    // Best-score register. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_score = best_q;
`else
    assign best_score = '0;
`endif

    assign load_timer = (state_q == ST_IDLE);
    assign tick_en    = tick_en_q;
    assign state      = state_q;
    assign score      = score_q;
    assign round_over = round_over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_round_ctrl
//
// Directed bench for game_round_ctrl with CLK_HZ=10, TICK_HZ=1 (DIV=10) and
// SCORE_BITS=2. It pairs the controller with a small countdown timer model
// whose start value is 3. Inputs change 1 time unit after a rising edge, so
// "cycle n" is the interval after edge n. Outputs are sampled in that same
// interval.
// ---------------------------------------------------------------------------
module tb_game_round_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

`ifdef GAME_ROUND_CTRL_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic       pause_btn;
    logic       hit;
    logic       timer_done;
    logic       load_timer;
    logic       tick_en;
    logic [1:0] state;
    logic [1:0] score;
    logic [1:0] best_score;
    logic       round_over;

    logic [1:0] tmr;
    logic       force_done;

    int total;
    int bad;

    game_round_ctrl #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .SCORE_BITS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .hit        (hit),
        .timer_done (timer_done),
        .load_timer (load_timer),
        .tick_en    (tick_en),
        .state      (state),
        .score      (score),
        .best_score (best_score),
        .round_over (round_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Countdown timer with start value 3. It reloads while load_timer is high
    // and decrements on tick_en down to 0.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= 2'd3;
        end else if (load_timer) begin
            tmr <= 2'd3;
        end else if (tick_en && (tmr != 2'd0)) begin
            tmr <= tmr - 2'd1;
        end
    end

    assign timer_done = (tmr == 2'd0) || force_done;

    function automatic logic [1:0] exp_best(input logic [1:0] v);
        return BEST_EN ? v : 2'd0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic pulse_hit;
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    // Bounded wait for the round to end.
    task automatic wait_over(input string name);
        int n;
        n = 0;
        while ((state !== S_OVER) && (n < 200)) begin
            step();
            n++;
        end
        total++;
        if (state !== S_OVER) begin
            $display("[TB] FAIL %s_timeout: state=%0d required=%0d", name, state, S_OVER);
            bad++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        total++; if (state !== S_IDLE) begin $display("[TB] FAIL reset_state: got %0d want %0d", state, S_IDLE); bad++; end
        total++; if (load_timer !== 1'b1) begin $display("[TB] FAIL reset_load: got %0b want 1", load_timer); bad++; end
        total++; if (tick_en !== 1'b0) begin $display("[TB] FAIL reset_tick: got %0b want 0", tick_en); bad++; end
        total++; if (score !== 2'd0) begin $display("[TB] FAIL reset_score: got %0d want 0", score); bad++; end
        total++; if (best_score !== 2'd0) begin $display("[TB] FAIL reset_best: got %0d want 0", best_score); bad++; end
        total++; if (round_over !== 1'b0) begin $display("[TB] FAIL reset_round_over: got %0b want 0", round_over); bad++; end
        reset = 1'b0;
        step();
    endtask

    // Start in cycle 0. RUN from cycle 1, ticks in cycles 11/21/31, timer at
    // 0 in cycle 32, OVER and round_over in cycle 33.
    task automatic test_start_expiry;
        logic       e_tick;
        logic [1:0] e_state;
        pulse_start();
        for (int c = 1; c <= 40; c++) begin
            e_tick  = (c == 11) || (c == 21) || (c == 31);
            e_state = (c <= 32) ? S_RUN : S_OVER;
            total++; if (tick_en !== e_tick) begin $display("[TB] FAIL expiry_tick c=%0d: got %0b want %0b", c, tick_en, e_tick); bad++; end
            total++; if (state !== e_state) begin $display("[TB] FAIL expiry_state c=%0d: got %0d want %0d", c, state, e_state); bad++; end
            total++; if (round_over !== (c == 33)) begin $display("[TB] FAIL expiry_round_over c=%0d: got %0b want %0b", c, round_over, (c == 33)); bad++; end
            total++; if (load_timer !== 1'b0) begin $display("[TB] FAIL expiry_load c=%0d: got %0b want 0", c, load_timer); bad++; end
            step();
        end
        pulse_start();
        total++; if (state !== S_IDLE) begin $display("[TB] FAIL over_to_idle: got %0d want %0d", state, S_IDLE); bad++; end
        total++; if (load_timer !== 1'b1) begin $display("[TB] FAIL idle_load: got %0b want 1", load_timer); bad++; end
    endtask

    // Hit in cycle 1, pause in cycle 5, 20 paused cycles (6..25) with hits,
    // resume in cycle 26, tick expected in cycle 32, then abort from PAUSE.
    task automatic test_pause;
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            hit = (c == 1);
            total++; if (tick_en !== 1'b0) begin $display("[TB] FAIL pause_pre_tick c=%0d: got %0b want 0", c, tick_en); bad++; end
            step();
        end
        hit = 1'b0;
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        for (int c = 6; c <= 25; c++) begin
            hit = (c % 3 == 0);
            total++; if (state !== S_PAUSE) begin $display("[TB] FAIL pause_state c=%0d: got %0d want %0d", c, state, S_PAUSE); bad++; end
            total++; if (tick_en !== 1'b0) begin $display("[TB] FAIL pause_tick c=%0d: got %0b want 0", c, tick_en); bad++; end
            total++; if (score !== 2'd1) begin $display("[TB] FAIL pause_score c=%0d: got %0d want 1", c, score); bad++; end
            step();
        end
        hit = 1'b0;
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        for (int c = 27; c <= 33; c++) begin
            total++; if (state !== S_RUN) begin $display("[TB] FAIL resume_state c=%0d: got %0d want %0d", c, state, S_RUN); bad++; end
            total++; if (tick_en !== (c == 32)) begin $display("[TB] FAIL resume_tick c=%0d: got %0b want %0b", c, tick_en, (c == 32)); bad++; end
            step();
        end
        total++; if (score !== 2'd1) begin $display("[TB] FAIL resume_score: got %0d want 1", score); bad++; end
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        total++; if (state !== S_PAUSE) begin $display("[TB] FAIL repause_state: got %0d want %0d", state, S_PAUSE); bad++; end
        pulse_start();
        total++; if (state !== S_IDLE) begin $display("[TB] FAIL abort_state: got %0d want %0d", state, S_IDLE); bad++; end
        total++; if (best_score !== 2'd0) begin $display("[TB] FAIL abort_best: got %0d want 0", best_score); bad++; end
    endtask

    task automatic test_best_score;
        pulse_start();
        pulse_hit();
        pulse_hit();
        wait_over("best_r1");
        total++; if (score !== 2'd2) begin $display("[TB] FAIL best_r1_score: got %0d want 2", score); bad++; end
        total++; if (best_score !== exp_best(2'd2)) begin $display("[TB] FAIL best_r1_best: got %0d want %0d", best_score, exp_best(2'd2)); bad++; end
        pulse_start();
        pulse_start();
        total++; if (score !== 2'd0) begin $display("[TB] FAIL best_r2_clear: got %0d want 0", score); bad++; end
        pulse_hit();
        wait_over("best_r2");
        total++; if (score !== 2'd1) begin $display("[TB] FAIL best_r2_score: got %0d want 1", score); bad++; end
        total++; if (best_score !== exp_best(2'd2)) begin $display("[TB] FAIL best_r2_best: got %0d want %0d", best_score, exp_best(2'd2)); bad++; end
        pulse_start();
    endtask

    // Two hits, then hit + timer_done + pause_btn together: OVER wins and the
    // third hit is counted and lifts best to 3.
    task automatic test_simultaneous;
        pulse_start();
        pulse_hit();
        pulse_hit();
        hit = 1'b1;
        force_done = 1'b1;
        pause_btn = 1'b1;
        step();
        hit = 1'b0;
        force_done = 1'b0;
        pause_btn = 1'b0;
        total++; if (state !== S_OVER) begin $display("[TB] FAIL simul_state: got %0d want %0d", state, S_OVER); bad++; end
        total++; if (round_over !== 1'b1) begin $display("[TB] FAIL simul_round_over: got %0b want 1", round_over); bad++; end
        total++; if (score !== 2'd3) begin $display("[TB] FAIL simul_score: got %0d want 3", score); bad++; end
        total++; if (best_score !== exp_best(2'd3)) begin $display("[TB] FAIL simul_best: got %0d want %0d", best_score, exp_best(2'd3)); bad++; end
        step();
        total++; if (round_over !== 1'b0) begin $display("[TB] FAIL simul_round_over_fall: got %0b want 0", round_over); bad++; end
        pulse_start();
    endtask

    task automatic test_saturation;
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            pulse_hit();
            total++; if (score !== exp_seq[i]) begin $display("[TB] FAIL sat_score hit%0d: got %0d want %0d", i + 1, score, exp_seq[i]); bad++; end
        end
        wait_over("sat");
        total++; if (best_score !== exp_best(2'd3)) begin $display("[TB] FAIL sat_best: got %0d want %0d", best_score, exp_best(2'd3)); bad++; end
        pulse_start();
    endtask

    task automatic test_reset_mid_run;
        pulse_start();
        pulse_hit();
        for (int i = 0; i < 9; i++) begin
            step();
        end
        total++; if (state !== S_RUN) begin $display("[TB] FAIL midrun_pre_state: got %0d want %0d", state, S_RUN); bad++; end
        total++; if (tick_en !== 1'b1) begin $display("[TB] FAIL midrun_pre_tick: got %0b want 1", tick_en); bad++; end
        #2;
        reset = 1'b1;
        #1;
        total++; if (state !== S_IDLE) begin $display("[TB] FAIL midrun_state: got %0d want %0d", state, S_IDLE); bad++; end
        total++; if (load_timer !== 1'b1) begin $display("[TB] FAIL midrun_load: got %0b want 1", load_timer); bad++; end
        total++; if (tick_en !== 1'b0) begin $display("[TB] FAIL midrun_tick: got %0b want 0", tick_en); bad++; end
        total++; if (score !== 2'd0) begin $display("[TB] FAIL midrun_score: got %0d want 0", score); bad++; end
        total++; if (best_score !== 2'd0) begin $display("[TB] FAIL midrun_best: got %0d want 0", best_score); bad++; end
        total++; if (round_over !== 1'b0) begin $display("[TB] FAIL midrun_round_over: got %0b want 0", round_over); bad++; end
        step();
        reset = 1'b0;
        step();
        total++; if (state !== S_IDLE) begin $display("[TB] FAIL post_reset_state: got %0d want %0d", state, S_IDLE); bad++; end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        start_btn  = 1'b0;
        pause_btn  = 1'b0;
        hit        = 1'b0;
        force_done = 1'b0;
        test_reset();
        test_start_expiry();
        test_pause();
        test_best_score();
        test_simultaneous();
        test_saturation();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round-sequencing controller that drives the game's countdown timer from the controller side. It generates the slow-tick `tick_en` enable, holds the timer in reload while idle, and detects `timer_done` to end a round. It also keeps the live score and the best score. It sits between the debounced button inputs and the countdown timer instance, and its `state`/`score` outputs feed the display path.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `TICK_HZ`, 1, tick rate; divide ratio DIV = CLK_HZ/TICK_HZ, must be ≥ 2
- `SCORE_BITS`, 8, score counter width
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `start_btn`  in  1  one-cycle pulse, debounced
- `pause_btn`  in  1  one-cycle pulse, debounced, toggles pause
- `hit`  in  1  one-cycle pulse, scoring event
- `timer_done`  in  1  countdown reached zero
- `load_timer`  out  1  hold the countdown at its start value
- `tick_en`  out  1  one-cycle countdown enable pulse
- `state`  out  2  current state encoding
- `score`  out  SCORE_BITS  current round score
- `best_score`  out  SCORE_BITS  highest completed-round score
- `round_over`  out  1  one-cycle pulse on entry to OVER

## Operation
- States and encodings: IDLE=0, RUN=1, PAUSE=2, OVER=3.
- IDLE:
  - `load_timer`=1, continuously.
  - `start_btn` → RUN; `score` cleared and prescaler cleared on the same edge.
- RUN:
  - `load_timer`=0.
  - Prescaler counts 0..DIV-1 and wraps.
  - `tick_en` fires once per DIV cycles.
  - `hit` increments `score`, saturating at 2^SCORE_BITS-1.
  - `timer_done`=1 → OVER.
  - `pause_btn` → PAUSE.
  - `start_btn` is ignored.
- PAUSE:
  - Prescaler holds its value; `tick_en`=0; `hit` is ignored.
  - `pause_btn` → RUN and the prescaler resumes from the held value.
  - `start_btn` → IDLE (abort; `best_score` is not updated).
- OVER:
  - `load_timer`=0, so the timer stays at 0; `tick_en`=0.
  - `start_btn` → IDLE.
- Simultaneous events in RUN:
  - `timer_done` has priority over `pause_btn`.
  - A `hit` in the same cycle as `timer_done` is still counted, and the counted value participates in the best-score compare.
- Best score: on the RUN→OVER edge, `best_score` ← max(`best_score`, final score including the same-cycle hit).
- `best_score` is cleared only by `reset`.

## Timing
- Reset values:
  - `state`=IDLE
  - `load_timer`=1
  - `tick_en`=0
  - `score`=0
  - `best_score`=0
  - `round_over`=0
  - prescaler=0
- All outputs are registered. `load_timer` is decoded from registered state.
- Tick timing: with the RUN-entry edge at cycle 0, `tick_en` is high in cycles DIV, 2·DIV, … (one cycle wide, never back-to-back).
- `timer_done` is sampled each RUN cycle. When high, `state`=OVER and `round_over`=1 from the next edge; `round_over` falls one cycle later.
- `score` updates on the edge after `hit`.
- Reset mid-round: all state returns to reset values immediately (asynchronous). The timer is reloaded through `load_timer`=1.

## Configuration
- `GAME_ROUND_CTRL_BEST_SCORE_EN`
  - Defined: the best-score register and compare are implemented as above.
  - Undefined: the register is not built and `best_score` is tied to 0. The port remains.

## Structure
- Shared package `game_pkg`:
  - 2-bit state typedef and encodings (IDLE/RUN/PAUSE/OVER)
  - default `CLK_HZ`/`TICK_HZ`
  - score-width constant
- Sub-module `tick_prescaler`:
  - Inputs: `clk`, `reset`, `clear`, `run`. Output: `tick`.
  - Parameter DIV.
  - Used here with `clear` on IDLE→RUN and `run` while in RUN.

## Test plan
Bench setup: CLK_HZ=10, TICK_HZ=1 (DIV=10), paired with a countdown timer of start value 3.

- Start round: `start_btn` at cycle 0 → `state`=RUN at cycle 1, `load_timer`=0, `tick_en` high in cycles 11, 21, 31.
- Timer expiry: after the 3rd tick `timer_done`=1 → `state`=OVER and `round_over` pulsed for exactly 1 cycle; `tick_en` stays 0 afterwards.
- Pause: `pause_btn` 4 cycles after RUN entry, held 20 cycles, then `pause_btn` again → first `tick_en` occurs 6 cycles after resume; no ticks or score changes while paused.
- Score saturation: SCORE_BITS=2, 5 `hit` pulses in RUN → `score` steps 1, 2, 3, 3, 3.
- Best score: round 1 with 2 hits then expiry → `best_score`=2. Round 2 with 1 hit → `best_score` stays 2, `score`=1. Without the macro defined, `best_score`=0 throughout.
- Simultaneous events and reset:
  - `hit` + `timer_done` + `pause_btn` in the same cycle → `state`=OVER, hit counted.
  - `reset` mid-RUN → all outputs return to reset values the same cycle.
